shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 91 +++++++++
 tb/tb_shift_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// Iterative log-shifter: one binary stage of the shift amount per cycle, so
// latency is a fixed SHW cycles regardless of Shamt. Valid/ready on both sides.
module shift_unit #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] InA,
  input  logic [SHW-1:0]   Shamt,
  input  logic [1:0]       Op,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROTR} op_e;

  localparam logic [SHW-1:0] LAST = SHW'(SHW - 1);

  state_e           state;
  op_e              op_q;
  logic [SHW-1:0]   shamt_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-1:0] next_work;

  // SRA keeps the working MSB equal to the latched operand's sign bit, so an
  // arithmetic step on the working value fills with that bit.
  always_comb begin
    amt     = SHW'(1) << cnt;
    stepped = work;
    case (op_q)
      OP_SLL:  stepped = work << amt;
      OP_SRL:  stepped = work >> amt;
      OP_SRA:  stepped = WIDTH'($signed(work) >>> amt);
      OP_ROTR: stepped = (work >> amt) | (work << (WIDTH - int'(amt)));
      default: stepped = work;
    endcase
    next_work = shamt_q[cnt] ? stepped : work;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      op_q      <= OP_SLL;
      shamt_q   <= '0;
      cnt       <= '0;
      work      <= '0;
      Out       <= '0;
      Out_valid <= 1'b0;
      In_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (In_valid) begin
            work     <= InA;
            shamt_q  <= Shamt;
            op_q     <= op_e'(Op);
            cnt      <= '0;
            In_ready <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          work <= next_work;
          cnt  <= cnt + SHW'(1);
          if (cnt == LAST) begin
            Out       <= next_work;
            Out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (Out_ready) begin
            Out_valid <= 1'b0;
            In_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench for shift_unit at WIDTH=32 and WIDTH=8: the driver queues
// reference results, per-instance monitors pop them when Out_valid rises.
module tb_shift_unit;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic Rst_n;

  logic        iv, ir, ov, ordy;
  logic [31:0] a, o;
  logic [4:0]  sh;
  logic [1:0]  op;

  logic        iv8, ir8, ov8, ordy8;
  logic [7:0]  a8, o8;
  logic [2:0]  sh8;
  logic [1:0]  op8;

  shift_unit #(.WIDTH(32)) dut32 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(iv), .In_ready(ir), .InA(a),
    .Shamt(sh), .Op(op), .Out_valid(ov), .Out_ready(ordy), .Out(o)
  );

  shift_unit #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(iv8), .In_ready(ir8), .InA(a8),
    .Shamt(sh8), .Op(op8), .Out_valid(ov8), .Out_ready(ordy8), .Out(o8)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rand_bp = 1'b0;

  always @(posedge Clk) cyc++;

  typedef struct {
    logic [63:0] res;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  // Bitwise reference: each output bit named by where it comes from.
  function automatic logic [63:0] ref_shift(logic [63:0] x, int w, int s, logic [1:0] f);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (f)
        2'd0: r[i] = (i >= s) ? x[i-s] : 1'b0;
        2'd1: r[i] = (i + s < w) ? x[i+s] : 1'b0;
        2'd2: r[i] = (i + s < w) ? x[i+s] : x[w-1];
        default: r[i] = x[(i + s) % w];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitors sample on the falling edge, away from the DUT's active edge.
  logic        pv32 = 1'b0;
  logic [31:0] last32;
  always @(negedge Clk) begin
    exp_t e;
    if (ov && !pv32) begin
      if (q32.size() == 0) fail_now("unexpected32");
      else begin
        e = q32.pop_front();
        check("out32", 64'(o), e.res);
        check("lat32", 64'(cyc - e.acc), 64'd5);
      end
    end else if (ov && pv32) begin
      check("hold32", 64'(o), 64'(last32));
    end
    pv32   = ov;
    last32 = o;
  end

  logic pv8 = 1'b0;
  always @(negedge Clk) begin
    exp_t e;
    if (ov8 && !pv8) begin
      if (q8.size() == 0) fail_now("unexpected8");
      else begin
        e = q8.pop_front();
        check("out8", 64'(o8), e.res);
        check("lat8", 64'(cyc - e.acc), 64'd3);
      end
    end
    pv8 = ov8;
  end

  always @(negedge Clk) if (rand_bp) ordy = 1'($urandom % 2);

  task automatic issue32(input logic [31:0] x, input logic [4:0] s, input logic [1:0] f);
    int n = 0;
    @(negedge Clk);
    while (!ir) begin
      @(negedge Clk);
      n++;
      if (n > 80) begin
        fail_now("timeout_issue32");
        return;
      end
    end
    iv = 1'b1; a = x; sh = s; op = f;
    q32.push_back('{ref_shift(64'(x), 32, int'(s), f), cyc + 1});
    @(negedge Clk);
    iv = 1'b0; a = $urandom; sh = 5'($urandom); op = 2'($urandom);
  endtask

  task automatic issue8(input logic [7:0] x, input logic [2:0] s, input logic [1:0] f);
    int n = 0;
    @(negedge Clk);
    while (!ir8) begin
      @(negedge Clk);
      n++;
      if (n > 80) begin
        fail_now("timeout_issue8");
        return;
      end
    end
    iv8 = 1'b1; a8 = x; sh8 = s; op8 = f;
    q8.push_back('{ref_shift(64'(x), 8, int'(s), f), cyc + 1});
    @(negedge Clk);
    iv8 = 1'b0; a8 = 8'($urandom); sh8 = 3'($urandom); op8 = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 200) fail_now("timeout_drain");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int n;
    Rst_n = 1'b0;
    iv = 1'b0; a = '0; sh = '0; op = '0; ordy = 1'b1;
    iv8 = 1'b0; a8 = '0; sh8 = '0; op8 = '0; ordy8 = 1'b1;
    #12;
    check("rst_ready", 64'(ir), 64'd1);
    check("rst_valid", 64'(ov), 64'd0);
    check("rst_out", 64'(o), 64'd0);
    @(negedge Clk); #2 Rst_n = 1'b1;

    issue32(32'h0000_0001, 5'd31, 2'd0);
    issue32(32'h8000_0000, 5'd4, 2'd2);
    issue32(32'h8000_0000, 5'd4, 2'd1);
    issue32(32'h0000_00F1, 5'd4, 2'd3);
    for (int f = 0; f < 4; f++) issue32(32'hDEAD_BEEF, 5'd0, 2'(f));
    drain();

    // Backpressure: result must hold while new requests are offered.
    ordy = 1'b0;
    issue32(32'h1234_5678, 5'd7, 2'd3);
    n = 0;
    while (!ov && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 20) fail_now("timeout_bp");
    held = o;
    repeat (3) begin
      iv = 1'b1; a = $urandom; sh = 5'($urandom); op = 2'($urandom);
      @(negedge Clk);
      check("bp_valid", 64'(ov), 64'd1);
      check("bp_out", 64'(o), 64'(held));
      check("bp_ready", 64'(ir), 64'd0);
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge Clk); #1;
    check("bp_release_valid", 64'(ov), 64'd0);
    check("bp_release_ready", 64'(ir), 64'd1);
    @(posedge Clk); #1;
    check("bp_no_accept", 64'(ir), 64'd1);

    // Reset two edges after accept aborts the operation.
    issue32(32'hAAAA_5555, 5'd3, 2'd1);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    check("abort_out", 64'(o), 64'd0);
    check("abort_valid", 64'(ov), 64'd0);
    check("abort_ready", 64'(ir), 64'd1);
    q32.delete();
    @(posedge Clk); @(posedge Clk);
    @(negedge Clk); #2 Rst_n = 1'b1;
    issue32(32'h0000_0003, 5'd2, 2'd0);
    drain();

    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++)
      issue32($urandom, 5'($urandom), 2'($urandom));
    drain();
    rand_bp = 1'b0;
    ordy = 1'b1;

    issue8(8'h90, 3'd7, 2'd2);
    for (int k = 0; k < 12; k++)
      issue8(8'($urandom), 3'($urandom), 2'($urandom));
    drain();

    repeat (4) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
